toast_mem_stage: RTL and testbench
==================================

// Module: toast_mem_stage
// PURPOSE
//  Memory-access stage between EX and WB. Issues load/store requests to data memory over a
//  req/ack handshake, aligns store data and byte enables, and sign/zero-extends load data.
//  Holds the MEM/WB pipeline register whose outputs feed the writeback mux directly.
//  Stalls upstream while a memory access is outstanding.
// PARAMETERS
//  ADDR_WIDTH  32  width of DMEM_addr_o; byte address = EX_alu_result_i[ADDR_WIDTH-1:0]
// PORTS
//  clk_i             in   1   clock; all state updates on rising edge
//  rst_i             in   1   synchronous reset, active-high
//  EX_alu_result_i   in   32  effective address (mem op) or ALU result (non-mem op)
//  EX_rs2_data_i     in   32  store data (unaligned, low bytes significant)
//  EX_rd_addr_i      in   5   destination register
//  EX_funct3_i       in   3   access width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  EX_mem_rd_en_i    in   1   load
//  EX_mem_wr_en_i    in   1   store
//  EX_memtoreg_i     in   1   writeback selects load data
//  EX_rd_wr_en_i     in   1   register-file write enable
//  DMEM_req_o        out  1   access request; held until DMEM_ack_i
//  DMEM_we_o         out  1   1 = store
//  DMEM_addr_o       out  ADDR_WIDTH  word-aligned address (addr[1:0] forced 0)
//  DMEM_be_o         out  4   byte enables
//  DMEM_wdata_o      out  32  lane-aligned store data
//  DMEM_rdata_i      in   32  read data, valid in the cycle DMEM_ack_i=1
//  DMEM_ack_i        in   1   access complete
//  MEM_stall_o       out  1   upstream must hold EX_* inputs stable
//  MEM_access_err_o  out  1   registered 1-cycle pulse: misaligned or illegal funct3
//  MEM_rd_addr_o     out  5   registered, to WB
//  MEM_dout_o        out  32  registered extended load data, to WB
//  MEM_alu_result_o  out  32  registered EX_alu_result_i, to WB
//  MEM_memtoreg_o    out  1   registered, to WB
//  MEM_rd_wr_en_o    out  1   registered, to WB
// BEHAVIOUR
//  - Reset: state IDLE; all registered outputs 0. DMEM_req_o and MEM_stall_o are forced 0
//    while rst_i=1. Reset during WAIT abandons the access; a later stray ack is ignored.
//  - FSM IDLE/WAIT. IDLE: if a legal mem op is present, DMEM_req_o=1 combinationally.
//    If ack arrives the same cycle, the access completes with zero stall. Otherwise go to
//    WAIT, with MEM_stall_o=1.
//    WAIT: req held with identical addr/we/be/wdata, stall=1; on ack -> IDLE, stall=0 that cycle.
//  - Pipeline register loads on every cycle where stall=0. Non-mem ops pass through with
//    1-cycle latency. A completing access loads extended rdata into MEM_dout_o.
//    While stall=1, a bubble is loaded (MEM_rd_wr_en_o=0, MEM_memtoreg_o=0), so WB never
//    writes twice.
//  - Store alignment (off = addr[1:0]):
//    SB: be=0001<<off, wdata={4{rs2[7:0]}}
//    SH: be=0011<<off, wdata={2{rs2[15:0]}}
//    SW: be=1111, wdata=rs2
//    Loads: be=1111.
//  - Load extract: r = rdata >> (8*off).
//    B: sext r[7:0]; BU: zext r[7:0]; H/HU: sext/zext r[15:0]; W: rdata.
//  - Errors (no request issued, no stall, bubble written, MEM_access_err_o=1 next cycle):
//    H/HU/SH with off[0]=1; W/SW with off!=0; funct3 011/110/111, or BU/HU used on a store.
//  - rd_en and wr_en both 1: store wins and the load is ignored.
//  - Address wraps naturally at 2^ADDR_WIDTH; no range checking.
// STRUCTURE
//  - toast_pkg: FUNCT3_{LB,LH,LW,LBU,LHU,SB,SH,SW} constants and the MEM FSM state encoding.
//  - Sub-module toast_mem_align (combinational): store be/wdata generation, load
//    extract/extend, misalign detect. This block keeps the FSM, handshake and MEM/WB register.
// TESTING
//  1. ALU op, result 0x1234_5678, rd=5, rd_wr_en=1 -> next cycle MEM_alu_result_o=0x1234_5678,
//     MEM_rd_addr_o=5, no req.
//  2. SB addr 0x103, rs2 0xAABB_CCDD, ack same cycle -> be=1000, wdata=0xDDDD_DDDD,
//     addr=0x100, stall never set.
//  3. LB addr 0x202, rdata 0x0080_0000, ack after 3 cycles -> stall=1 for 3 cycles with bubbles,
//     then MEM_dout_o=0xFFFF_FF80, memtoreg=1.
//  4. LHU addr 0x301 -> no req, MEM_access_err_o pulses 1 cycle, MEM_rd_wr_en_o=0.
//  5. LW issued, rst_i asserted during WAIT, ack after reset -> outputs 0, state IDLE, ack ignored.
//  6. Back-to-back LW 0x0 / SW 0x4, ack same cycle each -> two requests on consecutive cycles,
//     MEM_dout_o = rdata of the first access.

Source files
------------

// File: rtl/toast_pkg.sv
// toast_pkg: shared funct3 encodings and MEM stage FSM states
package toast_pkg;
  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;
  typedef enum logic {ST_IDLE, ST_WAIT} mem_state_e;
endpackage

// File: rtl/toast_mem_align.sv
// toast_mem_align: store lane alignment, load extract/extend, misalign and illegal funct3 detect
module toast_mem_align
  import toast_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  input  logic        store,
  input  logic [31:0] rs2,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        err
);
  logic [7:0]  b;
  logic [15:0] h;
  logic        illegal, misal;
  always_comb begin
    b = rdata[{off, 3'b000} +: 8];
    h = off[1] ? rdata[31:16] : rdata[15:0];
    be = !store ? 4'hF :
         funct3 == FUNCT3_SB ? 4'b0001 << off :
         funct3 == FUNCT3_SH ? 4'b0011 << off : 4'hF;
    wdata = !store ? rs2 :
            funct3 == FUNCT3_SB ? {4{rs2[7:0]}} :
            funct3 == FUNCT3_SH ? {2{rs2[15:0]}} : rs2;
    load_data = funct3 == FUNCT3_LB  ? {{24{b[7]}}, b} :
                funct3 == FUNCT3_LBU ? {24'b0, b} :
                funct3 == FUNCT3_LH  ? {{16{h[15]}}, h} :
                funct3 == FUNCT3_LHU ? {16'b0, h} : rdata;
    // stores only have B/H/W; unsigned variants are load-only
    illegal = store ? !(funct3 == FUNCT3_SB || funct3 == FUNCT3_SH || funct3 == FUNCT3_SW)
                    : (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111);
    misal = (funct3[1:0] == 2'b01 && off[0]) || (funct3[1:0] == 2'b10 && off != 2'b00);
    err = illegal || misal;
  end
endmodule

// File: rtl/toast_mem_stage.sv
// toast_mem_stage: MEM pipeline stage with DMEM req/ack handshake and MEM/WB register
module toast_mem_stage
  import toast_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [31:0]           EX_alu_result_i,
  input  logic [31:0]           EX_rs2_data_i,
  input  logic [4:0]            EX_rd_addr_i,
  input  logic [2:0]            EX_funct3_i,
  input  logic                  EX_mem_rd_en_i,
  input  logic                  EX_mem_wr_en_i,
  input  logic                  EX_memtoreg_i,
  input  logic                  EX_rd_wr_en_i,
  output logic                  DMEM_req_o,
  output logic                  DMEM_we_o,
  output logic [ADDR_WIDTH-1:0] DMEM_addr_o,
  output logic [3:0]            DMEM_be_o,
  output logic [31:0]           DMEM_wdata_o,
  input  logic [31:0]           DMEM_rdata_i,
  input  logic                  DMEM_ack_i,
  output logic                  MEM_stall_o,
  output logic                  MEM_access_err_o,
  output logic [4:0]            MEM_rd_addr_o,
  output logic [31:0]           MEM_dout_o,
  output logic [31:0]           MEM_alu_result_o,
  output logic                  MEM_memtoreg_o,
  output logic                  MEM_rd_wr_en_o
);
  mem_state_e  state;
  logic        mem_op, err, bad_op, bubble;
  logic [31:0] load_data;
  toast_mem_align u_align (
    .off       (EX_alu_result_i[1:0]),
    .funct3    (EX_funct3_i),
    .store     (EX_mem_wr_en_i),
    .rs2       (EX_rs2_data_i),
    .rdata     (DMEM_rdata_i),
    .be        (DMEM_be_o),
    .wdata     (DMEM_wdata_o),
    .load_data (load_data),
    .err       (err)
  );
  assign mem_op = EX_mem_rd_en_i | EX_mem_wr_en_i;
  assign bad_op = mem_op & err & (state == ST_IDLE);
  assign DMEM_req_o = ~rst_i & ((state == ST_WAIT) | (mem_op & ~err));
  assign DMEM_we_o = EX_mem_wr_en_i;
  assign DMEM_addr_o = {EX_alu_result_i[ADDR_WIDTH-1:2], 2'b00};
  assign MEM_stall_o = DMEM_req_o & ~DMEM_ack_i;
  assign bubble = MEM_stall_o | bad_op;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state            <= ST_IDLE;
      MEM_access_err_o <= 1'b0;
      MEM_rd_addr_o    <= '0;
      MEM_dout_o       <= '0;
      MEM_alu_result_o <= '0;
      MEM_memtoreg_o   <= 1'b0;
      MEM_rd_wr_en_o   <= 1'b0;
    end else begin
      state            <= MEM_stall_o ? ST_WAIT : ST_IDLE;
      MEM_access_err_o <= bad_op;
      MEM_rd_addr_o    <= EX_rd_addr_i;
      MEM_alu_result_o <= EX_alu_result_i;
      MEM_memtoreg_o   <= ~bubble & EX_memtoreg_i;
      MEM_rd_wr_en_o   <= ~bubble & EX_rd_wr_en_i;
      // dout only changes when a load actually completes
      if (DMEM_req_o & DMEM_ack_i & ~EX_mem_wr_en_i) MEM_dout_o <= load_data;
    end
  end
endmodule

// File: tb/tb_toast_mem_stage.sv
// tb_toast_mem_stage: directed self-checking bench for toast_mem_stage
module tb_toast_mem_stage;
  logic        clk = 0, rst = 1;
  logic [31:0] alu, rs2, rdata;
  logic [4:0]  rd;
  logic [2:0]  f3;
  logic        rd_en, wr_en, m2r, rwe, ack;
  logic        req, we, stall, aerr, mtr_o, rwe_o;
  logic [31:0] addr, wdata, dout, alu_o;
  logic [3:0]  be;
  logic [4:0]  rd_o;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  toast_mem_stage dut (
    .clk_i(clk), .rst_i(rst),
    .EX_alu_result_i(alu), .EX_rs2_data_i(rs2), .EX_rd_addr_i(rd), .EX_funct3_i(f3),
    .EX_mem_rd_en_i(rd_en), .EX_mem_wr_en_i(wr_en), .EX_memtoreg_i(m2r), .EX_rd_wr_en_i(rwe),
    .DMEM_req_o(req), .DMEM_we_o(we), .DMEM_addr_o(addr), .DMEM_be_o(be), .DMEM_wdata_o(wdata),
    .DMEM_rdata_i(rdata), .DMEM_ack_i(ack), .MEM_stall_o(stall), .MEM_access_err_o(aerr),
    .MEM_rd_addr_o(rd_o), .MEM_dout_o(dout), .MEM_alu_result_o(alu_o),
    .MEM_memtoreg_o(mtr_o), .MEM_rd_wr_en_o(rwe_o)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic clear();
    alu = 0; rs2 = 0; rd = 0; f3 = 0; rd_en = 0; wr_en = 0; m2r = 0; rwe = 0; ack = 0; rdata = 0;
  endtask
  task automatic step();
    @(posedge clk); #1;
  endtask
  initial begin
    clear();
    alu = 32'h40; f3 = 3'b010; rd_en = 1;
    step(); step();
    check("rst_req", {31'b0, req}, 0);
    check("rst_stall", {31'b0, stall}, 0);
    check("rst_dout", dout, 0);
    check("rst_rwe", {31'b0, rwe_o}, 0);
    rst = 0; clear();
    // 1: plain ALU op
    alu = 32'h1234_5678; rd = 5; rwe = 1; #1;
    check("alu_noreq", {31'b0, req}, 0);
    step();
    check("alu_res", alu_o, 32'h1234_5678);
    check("alu_rd", {27'b0, rd_o}, 5);
    check("alu_rwe", {31'b0, rwe_o}, 1);
    // 2: SB with same-cycle ack
    clear(); alu = 32'h103; rs2 = 32'hAABB_CCDD; wr_en = 1; ack = 1; #1;
    check("sb_req", {31'b0, req}, 1);
    check("sb_we", {31'b0, we}, 1);
    check("sb_be", {28'b0, be}, 4'b1000);
    check("sb_wdata", wdata, 32'hDDDD_DDDD);
    check("sb_addr", addr, 32'h100);
    check("sb_stall", {31'b0, stall}, 0);
    step();
    check("sb_nostate", {31'b0, stall}, 0);
    // 3: LB with ack on the 4th request cycle
    clear(); alu = 32'h202; rd_en = 1; m2r = 1; rwe = 1; rd = 7; #1;
    for (int i = 0; i < 3; i++) begin
      check("lb_stall", {31'b0, stall}, 1);
      check("lb_req", {31'b0, req}, 1);
      step();
      check("lb_bubble_rwe", {31'b0, rwe_o}, 0);
      check("lb_bubble_m2r", {31'b0, mtr_o}, 0);
    end
    ack = 1; rdata = 32'h0080_0000; #1;
    check("lb_ack_stall", {31'b0, stall}, 0);
    check("lb_be", {28'b0, be}, 4'hF);
    step(); clear();
    check("lb_dout", dout, 32'hFFFF_FF80);
    check("lb_m2r", {31'b0, mtr_o}, 1);
    check("lb_rwe", {31'b0, rwe_o}, 1);
    check("lb_rd", {27'b0, rd_o}, 7);
    // 4: misaligned LHU
    alu = 32'h301; f3 = 3'b101; rd_en = 1; m2r = 1; rwe = 1; #1;
    check("lhu_noreq", {31'b0, req}, 0);
    check("lhu_nostall", {31'b0, stall}, 0);
    step(); clear();
    check("lhu_err", {31'b0, aerr}, 1);
    check("lhu_rwe", {31'b0, rwe_o}, 0);
    step();
    check("lhu_err_pulse", {31'b0, aerr}, 0);
    // 5: reset during WAIT, stray ack afterwards
    alu = 32'h40; f3 = 3'b010; rd_en = 1; rwe = 1; m2r = 1; rd = 9; #1;
    check("rw_req", {31'b0, req}, 1);
    step();
    check("rw_wait_stall", {31'b0, stall}, 1);
    rst = 1; #1;
    check("rw_rst_req", {31'b0, req}, 0);
    check("rw_rst_stall", {31'b0, stall}, 0);
    step(); rst = 0; clear(); ack = 1; rdata = 32'h5555_5555; #1;
    check("rw_stray_req", {31'b0, req}, 0);
    check("rw_stray_stall", {31'b0, stall}, 0);
    check("rw_rd_o", {27'b0, rd_o}, 0);
    step(); ack = 0;
    check("rw_dout", dout, 0);
    check("rw_rwe", {31'b0, rwe_o}, 0);
    // 6: back-to-back LW / SW
    clear(); alu = 32'h0; f3 = 3'b010; rd_en = 1; rd = 3; rwe = 1; m2r = 1; ack = 1;
    rdata = 32'hCAFE_BABE; #1;
    check("b2b_lw_req", {31'b0, req}, 1);
    check("b2b_lw_we", {31'b0, we}, 0);
    step();
    clear(); alu = 32'h4; rs2 = 32'h1122_3344; f3 = 3'b010; wr_en = 1; ack = 1;
    rdata = 32'hDEAD_BEEF; #1;
    check("b2b_sw_req", {31'b0, req}, 1);
    check("b2b_sw_we", {31'b0, we}, 1);
    check("b2b_sw_addr", addr, 32'h4);
    check("b2b_sw_wdata", wdata, 32'h1122_3344);
    check("b2b_sw_stall", {31'b0, stall}, 0);
    check("b2b_lw_dout", dout, 32'hCAFE_BABE);
    step(); clear();
    check("b2b_dout_hold", dout, 32'hCAFE_BABE);
    check("b2b_sw_rwe", {31'b0, rwe_o}, 0);
    // extra alignment and extension cases
    alu = 32'h12; rs2 = 32'h0000_1234; f3 = 3'b001; wr_en = 1; ack = 1; #1;
    check("sh_be", {28'b0, be}, 4'b1100);
    check("sh_wdata", wdata, 32'h1234_1234);
    step(); clear();
    alu = 32'h102; f3 = 3'b001; rd_en = 1; ack = 1; rdata = 32'h8001_0000; step(); clear();
    check("lh_sext", dout, 32'hFFFF_8001);
    alu = 32'h203; f3 = 3'b100; rd_en = 1; ack = 1; rdata = 32'h9A00_0000; step(); clear();
    check("lbu_zext", dout, 32'h0000_009A);
    alu = 32'h5; f3 = 3'b010; wr_en = 1; #1;
    check("sw_mis_noreq", {31'b0, req}, 0);
    step(); clear();
    check("sw_mis_err", {31'b0, aerr}, 1);
    alu = 32'h0; f3 = 3'b100; wr_en = 1; #1;
    check("sbu_illegal", {31'b0, req}, 0);
    step(); clear();
    check("sbu_err", {31'b0, aerr}, 1);
    alu = 32'h8; f3 = 3'b000; rd_en = 1; wr_en = 1; rs2 = 32'h77; ack = 1; rdata = 32'h1; #1;
    check("both_we", {31'b0, we}, 1);
    check("both_be", {28'b0, be}, 4'b0001);
    step(); clear();
    check("both_no_load", dout, 32'h0000_009A);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
